// File: rtl/cache_arbiter_pkg.sv
// arbiter_pkg: shared state and requester encodings for cache_arbiter.
package arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2} arb_state_t;
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} arb_req_t;
endpackage

// File: rtl/cache_arbiter_picker.sv
// arb_picker: chooses the next requester; CACHE_ARBITER_RR_EN selects round-robin, else D-cache wins ties.
module arb_picker
  import arbiter_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
`ifdef CACHE_ARBITER_RR_EN
  input  arb_req_t ptr,
`endif
  output arb_req_t pick
);
`ifdef CACHE_ARBITER_RR_EN
  assign pick = (i_req && d_req) ? ptr : (i_req ? REQ_I : REQ_D);
`else
  assign pick = (i_req && !d_req) ? REQ_I : REQ_D;
`endif
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: grants the shared cacheline adapter to the I-cache or D-cache one line at a time.
// Define CACHE_ARBITER_RR_EN for round-robin tie-breaking; otherwise the D-cache has fixed priority.
module cache_arbiter
  import arbiter_pkg::*;
#(
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              ca_read,
  output logic              ca_write,
  output logic [31:0]       ca_addr,
  output logic [s_line-1:0] ca_wdata,
  input  logic [s_line-1:0] ca_rdata,
  input  logic              ca_resp
);
  arb_state_t state_q, state_d;
  arb_req_t   pick;
  logic       d_req, gnt_i, gnt_d;
  assign d_req = d_read | d_write;
  assign gnt_i = state_q == GRANT_I;
  assign gnt_d = state_q == GRANT_D;
`ifdef CACHE_ARBITER_RR_EN
  arb_req_t ptr_q, ptr_d;
  assign ptr_d = (state_q != IDLE && ca_resp) ? (ptr_q == REQ_I ? REQ_D : REQ_I) : ptr_q;
  arb_picker u_picker (.i_req(i_read), .d_req(d_req), .ptr(ptr_q), .pick(pick));
  always_ff @(posedge clk) ptr_q <= rst ? REQ_D : ptr_d;
`else
  arb_picker u_picker (.i_req(i_read), .d_req(d_req), .pick(pick));
`endif
  // Every completed grant passes through IDLE, so requesters are seen to drop between transactions.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = !(i_read || d_req) ? IDLE : (pick == REQ_I ? GRANT_I : GRANT_D);
    else if (ca_resp)
      state_d = IDLE;
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    ca_read  = gnt_i ? i_read : (gnt_d & d_read);
    ca_write = gnt_d & d_write;
    ca_addr  = gnt_i ? i_address : (gnt_d ? d_address : 32'd0);
    ca_wdata = d_wdata;
    i_resp   = gnt_i & ca_resp;
    d_resp   = gnt_d & ca_resp;
    i_rdata  = ca_rdata;
    d_rdata  = ca_rdata;
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed checks plus randomized two-cache traffic against a transaction-level reference model.
module tb_cache_arbiter;
  logic         clk = 1'b0;
  logic         rst, i_read, i_resp, d_read, d_write, d_resp, ca_read, ca_write, ca_resp;
  logic [31:0]  i_address, d_address, ca_addr;
  logic [255:0] i_rdata, d_rdata, d_wdata, ca_wdata, ca_rdata;
  int n_cmp = 0;
  int n_err = 0;
  logic [255:0] ref_mem [logic [31:0]];
  logic [255:0] ad_mem [logic [31:0]];

  always #5 clk = ~clk;

  cache_arbiter #(.s_line(256)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .ca_read(ca_read), .ca_write(ca_write), .ca_addr(ca_addr), .ca_wdata(ca_wdata),
    .ca_rdata(ca_rdata), .ca_resp(ca_resp)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic exp_out(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                         input logic ir, input logic dr);
    chk({tag, ".ca_read"}, 256'(ca_read), 256'(rd));
    chk({tag, ".ca_write"}, 256'(ca_write), 256'(wr));
    chk({tag, ".ca_addr"}, 256'(ca_addr), 256'(a));
    chk({tag, ".i_resp"}, 256'(i_resp), 256'(ir));
    chk({tag, ".d_resp"}, 256'(d_resp), 256'(dr));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  function automatic logic [255:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [255:0] ad_get(input logic [31:0] a);
    return ad_mem.exists(a) ? ad_mem[a] : init_line(a);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    logic [255:0] pa, pb, dwd, nrdata;
    logic [31:0]  ia, da, a1, a2;
    bit ip, dp, dw, ni, nd, ptr_m, nresp, first_i, tie_i, e_rd, e_wr, e_ir, e_dr;
    int owner, acnt, alat, starve, done, cyc;
    logic [31:0] e_addr;
    pa = {8{32'hDEAD_0060}};
    pb = {8{32'hBEEF_1020}};
    rst = 1; i_read = 0; i_address = 0; d_read = 0; d_write = 0; d_address = 0;
    d_wdata = 0; ca_resp = 0; ca_rdata = 0;
    nxt(); nxt(); smp();
    exp_out("reset", 0, 0, 0, 0, 0);
    nxt(); rst = 0;
    // I-cache read alone
    i_read = 1; i_address = 32'h60; smp(); exp_out("i_lat0", 0, 0, 0, 0, 0);
    nxt(); smp(); exp_out("i_gnt", 1, 0, 32'h60, 0, 0);
    nxt(); ca_resp = 1; ca_rdata = pa; smp(); exp_out("i_resp", 1, 0, 32'h60, 1, 0);
    chk("i_rdata", i_rdata, pa);
    nxt(); ca_resp = 0; i_read = 0; smp(); exp_out("i_done", 0, 0, 0, 0, 0);
    // D writeback then fill of the same line
    nxt(); d_write = 1; d_address = 32'h1020; d_wdata = pb; smp(); exp_out("d_idle", 0, 0, 0, 0, 0);
    nxt(); smp(); exp_out("d_wr_gnt", 0, 1, 32'h1020, 0, 0); chk("ca_wdata", ca_wdata, pb);
    nxt(); ca_resp = 1; smp(); exp_out("d_wr_resp", 0, 1, 32'h1020, 0, 1);
    nxt(); ca_resp = 0; d_write = 0; d_read = 1; smp(); exp_out("d_gap", 0, 0, 0, 0, 0);
    nxt(); smp(); exp_out("d_rd_gnt", 1, 0, 32'h1020, 0, 0);
    nxt(); ca_resp = 1; ca_rdata = pb; smp(); exp_out("d_rd_resp", 1, 0, 32'h1020, 0, 1);
    chk("d_rdata", d_rdata, pb);
    nxt(); ca_resp = 0; d_read = 0;
    // Simultaneous pair from reset: D first, I on the IDLE cycle after d_resp
    rst = 1; nxt(); rst = 0;
    i_read = 1; i_address = 32'h80; d_read = 1; d_address = 32'h2000;
    smp(); exp_out("pair_idle", 0, 0, 0, 0, 0);
    nxt(); smp(); exp_out("pair_d_first", 1, 0, 32'h2000, 0, 0);
    nxt(); ca_resp = 1; ca_rdata = pa; smp(); exp_out("pair_d_resp", 1, 0, 32'h2000, 0, 1);
    nxt(); ca_resp = 0; d_read = 0; smp(); exp_out("pair_gap", 0, 0, 0, 0, 0);
    nxt(); smp(); exp_out("pair_i_next", 1, 0, 32'h80, 0, 0);
    nxt(); ca_resp = 1; smp(); exp_out("pair_i_resp", 1, 0, 32'h80, 1, 0);
    nxt(); ca_resp = 0; i_read = 0;
    // After one D grant, a tie goes to I only with round-robin
    d_read = 1; d_address = 32'h2040; smp();
    nxt(); smp(); exp_out("rr_d", 1, 0, 32'h2040, 0, 0);
    nxt(); ca_resp = 1; smp(); exp_out("rr_d_resp", 1, 0, 32'h2040, 0, 1);
    nxt(); ca_resp = 0; d_read = 0; smp(); exp_out("rr_gap", 0, 0, 0, 0, 0);
`ifdef CACHE_ARBITER_RR_EN
    first_i = 1;
`else
    first_i = 0;
`endif
    a1 = first_i ? 32'h84 : 32'h2060;
    a2 = first_i ? 32'h2060 : 32'h84;
    nxt(); i_read = 1; i_address = 32'h84; d_read = 1; d_address = 32'h2060;
    smp(); exp_out("pair2_idle", 0, 0, 0, 0, 0);
    nxt(); smp(); exp_out("pair2_first", 1, 0, a1, 0, 0);
    nxt(); ca_resp = 1; smp(); exp_out("pair2_resp1", 1, 0, a1, first_i, !first_i);
    nxt(); ca_resp = 0; if (first_i) i_read = 0; else d_read = 0;
    smp(); exp_out("pair2_gap", 0, 0, 0, 0, 0);
    nxt(); smp(); exp_out("pair2_second", 1, 0, a2, 0, 0);
    nxt(); ca_resp = 1; smp(); exp_out("pair2_resp2", 1, 0, a2, !first_i, first_i);
    nxt(); ca_resp = 0; i_read = 0; d_read = 0;
    // Reset during a long D grant aborts it silently
    d_read = 1; d_address = 32'h3000; nxt(); nxt(); smp();
    exp_out("rst_gnt", 1, 0, 32'h3000, 0, 0);
    repeat (3) nxt();
    rst = 1; d_read = 0; nxt(); rst = 0; smp();
    exp_out("rst_abort", 0, 0, 0, 0, 0);
    repeat (12) begin nxt(); smp(); exp_out("rst_noresp", 0, 0, 0, 0, 0); end
    // Spurious adapter response in IDLE
    nxt(); ca_resp = 1; smp(); exp_out("spur", 0, 0, 0, 0, 0);
    nxt(); ca_resp = 0; i_read = 1; i_address = 32'hC0; smp(); exp_out("spur_idle", 0, 0, 0, 0, 0);
    nxt(); smp(); exp_out("spur_state", 1, 0, 32'hC0, 0, 0);
    nxt(); ca_resp = 1; smp(); exp_out("spur_resp", 1, 0, 32'hC0, 1, 0);
    nxt(); ca_resp = 0; i_read = 0;
    // Randomized interleaved traffic
    rst = 1; nxt(); rst = 0;
    ip = 0; dp = 0; dw = 0; ia = 0; da = 0; dwd = 0; ptr_m = 1;
    owner = 0; acnt = 0; alat = 1; starve = 0; done = 0; cyc = 0;
    while (done < 10000 && cyc < 80000) begin
      smp();
      e_rd = owner == 1 ? ip : (owner == 2 && dp && !dw);
      e_wr = owner == 2 && dp && dw;
      e_addr = owner == 1 ? ia : (owner == 2 ? da : 32'd0);
      e_ir = owner == 1 && ca_resp;
      e_dr = owner == 2 && ca_resp;
      exp_out("rnd", e_rd, e_wr, e_addr, e_ir, e_dr);
      if (e_ir) chk("rnd.i_rdata", i_rdata, ref_get(ia));
      if (e_dr && !dw) chk("rnd.d_rdata", d_rdata, ref_get(da));
      if (e_wr) chk("rnd.ca_wdata", ca_wdata, dwd);
      if (d_resp && ip) starve++;
      if (i_resp) starve = 0;
      if (d_resp) chk("rnd.i_starve", 256'(starve <= 2), 256'(1));
      nresp = 0; nrdata = rnd_line();
      if (!ca_resp && (ca_read || ca_write)) begin
        acnt++;
        if (acnt >= alat) begin
          nresp = 1; acnt = 0; alat = $urandom_range(1, 3);
          if (ca_read) nrdata = ad_get(ca_addr);
          if (ca_write) ad_mem[ca_addr] = ca_wdata;
        end
      end
`ifdef CACHE_ARBITER_RR_EN
      tie_i = !ptr_m;
`else
      tie_i = 0;
`endif
      ni = ip; nd = dp;
      if (owner == 0) begin
        if (ip || dp) owner = (ip && (!dp || tie_i)) ? 1 : 2;
      end else if (ca_resp) begin
        if (owner == 1) ni = 0;
        else begin
          if (dw) ref_mem[da] = dwd;
          nd = 0;
        end
        done++; ptr_m = !ptr_m; owner = 0;
      end
      if (!ip && $urandom_range(0, 3) != 0) begin
        ni = 1; ia = 32'h100 + ($urandom_range(0, 15) << 5);
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        nd = 1; dw = 1'($urandom_range(0, 1)); da = 32'h100 + ($urandom_range(0, 15) << 5);
        dwd = rnd_line();
      end
      nxt();
      ip = ni; dp = nd;
      i_read = ip; i_address = ia;
      d_read = dp && !dw; d_write = dp && dw; d_address = da; d_wdata = dwd;
      ca_resp = nresp; ca_rdata = nrdata;
      cyc++;
    end
    chk("rnd.txn_count", 256'(done), 256'(10000));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
